// File: rtl/cpu_pkg.sv
// Shared constants for the 8-bit CPU datapath.
//   CPU_DATA_W / CPU_ADDR_W : default data and address widths
//   PC_SEQ / PC_JMP         : pc_src encodings (sequential increment / load target)
//   INC1 / INC2             : pc_increment encodings (PC+1 / PC+2)
package cpu_pkg;

    localparam int unsigned CPU_DATA_W = 8;
    localparam int unsigned CPU_ADDR_W = 8;

    localparam logic PC_SEQ = 1'b0;
    localparam logic PC_JMP = 1'b1;

    localparam logic INC1 = 1'b0;
    localparam logic INC2 = 1'b1;

endpackage

// File: rtl/pc_mem_pc_reg.sv
// Program counter next-state mux and register.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset (PC -> 0)
//   reset_req, intr_req         : level-sensitive vector loads, reset_req wins
//   pc_write, pc_src            : update enable and source (sequential / jump)
//   pc_increment                : sequential step size (+1 / +2)
//   pc_in                       : jump target
//   reset_vector, intr_vector   : vector values
//   pc                          : registered program counter
module pc_mem_pc_reg
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = CPU_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reset_req,
    input  logic              intr_req,
    input  logic              pc_write,
    input  logic              pc_src,
    input  logic              pc_increment,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [ADDR_W-1:0] reset_vector,
    input  logic [ADDR_W-1:0] intr_vector,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_step;

    // Arithmetic wraps naturally at ADDR_W bits.
    assign pc_step = (pc_increment == INC2) ? ADDR_W'(2) : ADDR_W'(1);

    always_comb begin
        pc_d = pc_q;
        if (reset_req) begin
            pc_d = reset_vector;
        end else if (intr_req) begin
            pc_d = intr_vector;
        end else if (pc_write) begin
            if (pc_src == PC_JMP) begin
                pc_d = pc_in;
            end else begin
                pc_d = pc_q + pc_step;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/pc_mem_subsystem.sv
// Fetch- and data-side storage: PC register, 256x8 instruction memory read at PC
// (combinational, no write port, loaded by backdoor) and 256x8 read/write data/stack
// memory (synchronous write, combinational read gated by mem_read).
// Ports:
//   clk, rst                          : clock, synchronous active-high reset (PC only)
//   RESET_IN, INTR_IN                 : vector load requests (RESET_IN has priority)
//   pc_write, pc_src, pc_increment    : PC update controls
//   pc_in, reset_vector, intr_vector  : PC load sources
//   PC, instruction                   : current PC and imem_mem[PC]
//   mem_read, mem_write, address      : data memory strobes and address
//   data_in, data_out                 : data memory write/read data
module pc_mem_subsystem
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = CPU_DATA_W,
    parameter int unsigned ADDR_W = CPU_ADDR_W,
    parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RESET_IN,
    input  logic              INTR_IN,
    input  logic              pc_write,
    input  logic              pc_src,
    input  logic              pc_increment,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [ADDR_W-1:0] reset_vector,
    input  logic [ADDR_W-1:0] intr_vector,
    output logic [ADDR_W-1:0] PC,
    output logic [DATA_W-1:0] instruction,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out
);

    // Memories are kept at this level so testbenches can reach them by name.
    // Neither array is touched by rst so backdoor-loaded programs survive reset.
    logic [DATA_W-1:0] imem_mem [0:DEPTH-1];
    logic [DATA_W-1:0] dmem_mem [0:DEPTH-1];

    pc_mem_pc_reg #(
        .ADDR_W (ADDR_W)
    ) u_pc_reg (
        .clk          (clk),
        .rst          (rst),
        .reset_req    (RESET_IN),
        .intr_req     (INTR_IN),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .pc_increment (pc_increment),
        .pc_in        (pc_in),
        .reset_vector (reset_vector),
        .intr_vector  (intr_vector),
        .pc           (PC)
    );

    assign instruction = imem_mem[PC];

    always_ff @(posedge clk) begin
        if (mem_write) begin
            dmem_mem[address] <= data_in;
        end
    end

    // No write bypass: a same-cycle write is visible only after the edge.
    assign data_out = mem_read ? dmem_mem[address] : '0;

endmodule

// File: tb/tb_pc_mem_subsystem.sv
module tb_pc_mem_subsystem;

    logic       clk = 1'b0;
    logic       rst;
    logic       RESET_IN, INTR_IN;
    logic       pc_write, pc_src, pc_increment;
    logic [7:0] pc_in, reset_vector, intr_vector;
    logic [7:0] PC, instruction;
    logic       mem_read, mem_write;
    logic [7:0] address, data_in, data_out;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    pc_mem_subsystem dut (
        .clk          (clk),
        .rst          (rst),
        .RESET_IN     (RESET_IN),
        .INTR_IN      (INTR_IN),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .pc_increment (pc_increment),
        .pc_in        (pc_in),
        .reset_vector (reset_vector),
        .intr_vector  (intr_vector),
        .PC           (PC),
        .instruction  (instruction),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .address      (address),
        .data_in      (data_in),
        .data_out     (data_out)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic jump(input logic [7:0] target);
        pc_write = 1'b1;
        pc_src   = 1'b1;
        pc_in    = target;
        tick();
        pc_write = 1'b0;
        pc_src   = 1'b0;
    endtask

    task automatic dwrite(input logic [7:0] a, input logic [7:0] d);
        mem_write = 1'b1;
        address   = a;
        data_in   = d;
        tick();
        mem_write = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;  RESET_IN = 1'b0;  INTR_IN = 1'b0;
        pc_write = 1'b0;  pc_src = 1'b0;  pc_increment = 1'b0;
        pc_in = 8'h00;  reset_vector = 8'h00;  intr_vector = 8'h00;
        mem_read = 1'b0;  mem_write = 1'b0;  address = 8'h00;  data_in = 8'h00;

        dut.imem_mem[0] = 8'h00;
        dut.imem_mem[2] = 8'h29;
        dut.imem_mem[4] = 8'hC0;
        dut.imem_mem[5] = 8'h42;

        // Reset and hold
        tick();
        check("rst_pc", PC, 8'h00);
        check("rst_instr", instruction, 8'h00);
        rst = 1'b0;
        tick();
        check("hold_after_rst", PC, 8'h00);

        // Sequential +1
        pc_write = 1'b1;
        tick();
        check("inc1_a", PC, 8'h01);
        tick();
        check("inc1_b", PC, 8'h02);

        // Jump to 0x02 then +2 steps
        pc_src = 1'b1;  pc_in = 8'h02;
        tick();
        check("jmp_02", PC, 8'h02);
        check("instr_02", instruction, 8'h29);
        pc_src = 1'b0;  pc_increment = 1'b1;
        tick();
        check("inc2_a", PC, 8'h04);
        check("instr_04", instruction, 8'hC0);
        tick();
        check("inc2_b", PC, 8'h06);

        // Jump and hold
        pc_increment = 1'b0;
        jump(8'h20);
        check("jmp_20", PC, 8'h20);
        tick();
        tick();
        check("hold_20", PC, 8'h20);

        // Wrap-around cases
        jump(8'hFF);
        pc_write = 1'b1;  pc_increment = 1'b0;
        tick();
        check("wrap_ff_p1", PC, 8'h00);
        jump(8'hFE);
        pc_write = 1'b1;  pc_increment = 1'b1;
        tick();
        check("wrap_fe_p2", PC, 8'h00);
        jump(8'hFF);
        pc_write = 1'b1;  pc_increment = 1'b1;
        tick();
        check("wrap_ff_p2", PC, 8'h01);
        pc_write = 1'b0;  pc_increment = 1'b0;

        // Instruction fetch follows PC in the same cycle
        jump(8'h05);
        check("instr_05", instruction, 8'h42);
        jump(8'h04);
        check("instr_04b", instruction, 8'hC0);
        jump(8'h00);
        check("instr_00", instruction, 8'h00);
        dut.imem_mem[0] = 8'h77;
        #1;
        check("instr_async", instruction, 8'h77);

        // Data memory writes and combinational reads
        dwrite(8'h10, 8'hAB);
        dwrite(8'h11, 8'hCD);
        dwrite(8'h12, 8'hEF);
        mem_read = 1'b1;
        address = 8'h10;  #1;  check("rd_10", data_out, 8'hAB);
        address = 8'h11;  #1;  check("rd_11", data_out, 8'hCD);
        address = 8'h12;  #1;  check("rd_12", data_out, 8'hEF);
        mem_read = 1'b0;
        dwrite(8'hFF, 8'h11);
        dwrite(8'hFE, 8'h22);
        dwrite(8'hFD, 8'h33);
        mem_read = 1'b1;
        address = 8'hFD;  #1;  check("rd_fd", data_out, 8'h33);
        address = 8'hFE;  #1;  check("rd_fe", data_out, 8'h22);
        address = 8'hFF;  #1;  check("rd_ff", data_out, 8'h11);
        mem_read = 1'b0;  #1;  check("rd_gated", data_out, 8'h00);

        // Same-address read and write: old value until the edge
        mem_read = 1'b1;  mem_write = 1'b1;  address = 8'h10;  data_in = 8'h5A;
        #1;
        check("rw_before", data_out, 8'hAB);
        tick();
        mem_write = 1'b0;
        check("rw_after", data_out, 8'h5A);
        mem_read = 1'b0;

        // Interrupt and external reset vectors
        jump(8'h12);
        check("jmp_12", PC, 8'h12);
        intr_vector = 8'h50;  INTR_IN = 1'b1;
        tick();
        check("intr_load", PC, 8'h50);
        pc_write = 1'b1;  pc_src = 1'b0;
        tick();
        check("intr_level", PC, 8'h50);
        INTR_IN = 1'b0;  pc_write = 1'b0;
        tick();
        check("intr_release", PC, 8'h50);
        reset_vector = 8'h00;  RESET_IN = 1'b1;
        tick();
        check("reset_in", PC, 8'h00);
        RESET_IN = 1'b0;
        tick();
        check("reset_in_hold", PC, 8'h00);
        reset_vector = 8'h33;  RESET_IN = 1'b1;  INTR_IN = 1'b1;
        tick();
        check("reset_over_intr", PC, 8'h33);
        rst = 1'b1;
        tick();
        check("rst_over_reset_in", PC, 8'h00);
        RESET_IN = 1'b0;  INTR_IN = 1'b0;

        // rst leaves both memories intact
        tick();
        rst = 1'b0;
        check("rst_imem0", instruction, 8'h77);
        mem_read = 1'b1;
        address = 8'h10;  #1;  check("rst_dmem_10", data_out, 8'h5A);
        address = 8'hFF;  #1;  check("rst_dmem_ff", data_out, 8'h11);
        mem_read = 1'b0;
        jump(8'h05);
        check("rst_imem5", instruction, 8'h42);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
